matmul_sequencer: RTL and testbench
===================================

// Module: matmul_sequencer
// PURPOSE
//  Sequences the shared 16-bit ALU (MUL=01, ADD=10, NOP=00; output registered, 1-cycle latency)
//  to compute C = A x B for square NxN matrices held in a single-port word memory.
//  Fetches A/B operands, issues MUL then ADD per term, accumulates, writes each C element back.
//  Sits between the top-level start/done control, the data memory and the ALU.
// PARAMETERS
//  N       3    matrix dimension (>=1)
//  AW      8    memory address width
//  DW      16   data width (equals ALU width)
//  A_BASE  0    base address of A, row-major
//  B_BASE  16   base address of B, row-major
//  C_BASE  32   base address of C, row-major
// PORTS
//  clk          in   1   clock, all state changes on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   begin a multiply; sampled only in IDLE
//  busy         out  1   high in every state except IDLE
//  done         out  1   one-cycle pulse in DONE state
//  mem_addr     out  AW  memory address
//  mem_rd       out  1   read strobe; mem_rdata valid the following cycle
//  mem_rdata    in   DW  read data
//  mem_wr       out  1   write strobe; write occurs at this rising edge
//  mem_wdata    out  DW  write data
//  alu_in1      out  DW  ALU operand 1
//  alu_in2      out  DW  ALU operand 2
//  alu_control  out  2   ALU opcode
//  alu_out      in   DW  ALU registered result
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; i,j,k,acc,opa,opb,prod=0; all outputs 0 (alu_control=NOP).
//  - FSM states and transitions (one cycle each):
//    IDLE  : start=1 -> RD_A, clear i,j,k,acc; else stay.
//    RD_A  : mem_rd=1, mem_addr=A_BASE+i*N+k -> RD_B.
//    RD_B  : opa<=mem_rdata; mem_rd=1, mem_addr=B_BASE+k*N+j -> LD_B.
//    LD_B  : opb<=mem_rdata -> MUL.
//    MUL   : alu_in1=opa, alu_in2=opb, alu_control=01 -> MUL_W.
//    MUL_W : prod<=alu_out -> ADD.
//    ADD   : alu_in1=acc, alu_in2=prod, alu_control=10 -> ADD_W.
//    ADD_W : acc<=alu_out; k==N-1 -> WRITE, else k<=k+1 -> RD_A.
//    WRITE : mem_wr=1, mem_addr=C_BASE+i*N+j, mem_wdata=acc; acc<=0, k<=0;
//            j<N-1: j++ ; else j<=0, i++; last element (i=j=N-1) -> DONE, else -> RD_A.
//    DONE  : done=1 -> IDLE.
//  - alu_control=00 (NOP) in every state other than MUL and ADD; alu_in1/2=0 then.
//  - mem_rd and mem_wr never high together; mem_addr=0 when neither is high.
//  - Arithmetic: all products/sums truncated to DW bits (mod 2^DW), same as ALU; no saturation.
//  - Address arithmetic modulo 2^AW; bases + N*N must not overlap (integrator's responsibility).
//  - Latency: 7 cycles per term, 7N+1 per C element; done high exactly N*N*(7N+1)+1 cycles after
//    the edge that samples start (N=2: 61, N=3: 199).
//  - start while busy: ignored, no restart, no effect on counters. start held high in DONE
//    cycle: not sampled; sampled on next IDLE cycle (back-to-back run).
//  - Reset mid-operation: immediate return to IDLE; no further mem_wr; partial C left as is.
//  - N=1: single term, single WRITE, done at cycle 9.
// TESTING
//  1. N=2, A=[1 2;3 4], B=[5 6;7 8], pulse start -> mem C=[19 22;43 50], done at cycle 61, busy 1..60.
//  2. N=3, A=identity, B=1..9 -> C=1..9 written in row-major order, done at cycle 199.
//  3. N=2, A=B=all 256 -> products wrap, C all 0; A=B=all 255 -> C all 16'hFC02 (2*65025 mod 2^16).
//  4. N=2, pulse start again at cycle 20 -> ignored; single done at 61, exactly 4 writes.
//  5. N=2, rst_n low at cycle 30 -> busy/alu_control/mem_wr 0 immediately, only C[0][0],C[0][1]
//     written; new start afterwards -> full correct result.
//  6. Hold start high continuously -> done pulses at 61 and 123; mem_rd/mem_wr never coincide.

Source files
------------

// File: rtl/matmul_sequencer.sv
// Drives a shared registered ALU and a single-port memory to compute C = A x B for NxN matrices.
// Each term is fetch A, fetch B, MUL, ADD into the accumulator; each C element ends in one write.
module matmul_sequencer #(
  parameter int unsigned N      = 3,
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 16,
  parameter int unsigned A_BASE = 0,
  parameter int unsigned B_BASE = 16,
  parameter int unsigned C_BASE = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [1:0]    alu_control,
  input  logic [DW-1:0] alu_out
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] Last = CW'(N - 1);

  localparam logic [1:0] AluNop = 2'b00;
  localparam logic [1:0] AluMul = 2'b01;
  localparam logic [1:0] AluAdd = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StRdA, StRdB, StLdB, StMul, StMulW, StAdd, StAddW, StWrite, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [DW-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d, prod_q, prod_d;

  logic [AW-1:0] a_addr, b_addr, c_addr;

  // Row-major addressing, wrapping modulo 2^AW.
  assign a_addr = AW'(A_BASE) + AW'(i_q) * AW'(N) + AW'(k_q);
  assign b_addr = AW'(B_BASE) + AW'(k_q) * AW'(N) + AW'(j_q);
  assign c_addr = AW'(C_BASE) + AW'(i_q) * AW'(N) + AW'(j_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      prod_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      k_q    <= k_d;
      acc_q  <= acc_d;
      opa_q  <= opa_d;
      opb_q  <= opb_d;
      prod_q <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    prod_d  = prod_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRdA;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
        end
      end
      StRdA:  state_d = StRdB;
      StRdB: begin
        opa_d   = mem_rdata;
        state_d = StLdB;
      end
      StLdB: begin
        opb_d   = mem_rdata;
        state_d = StMul;
      end
      StMul:  state_d = StMulW;
      StMulW: begin
        prod_d  = alu_out;
        state_d = StAdd;
      end
      StAdd:  state_d = StAddW;
      StAddW: begin
        acc_d = alu_out;
        if (k_q == Last) begin
          state_d = StWrite;
        end else begin
          k_d     = k_q + CW'(1);
          state_d = StRdA;
        end
      end
      StWrite: begin
        acc_d   = '0;
        k_d     = '0;
        state_d = StRdA;
        if (j_q == Last) begin
          j_d = '0;
          i_d = i_q + CW'(1);
          if (i_q == Last) state_d = StDone;
        end else begin
          j_d = j_q + CW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = (state_q != StIdle);
    done        = 1'b0;
    mem_addr    = '0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_wdata   = '0;
    alu_in1     = '0;
    alu_in2     = '0;
    alu_control = AluNop;
    case (state_q)
      StRdA: begin
        mem_rd   = 1'b1;
        mem_addr = a_addr;
      end
      StRdB: begin
        mem_rd   = 1'b1;
        mem_addr = b_addr;
      end
      StMul: begin
        alu_in1     = opa_q;
        alu_in2     = opb_q;
        alu_control = AluMul;
      end
      StAdd: begin
        alu_in1     = acc_q;
        alu_in2     = prod_q;
        alu_control = AluAdd;
      end
      StWrite: begin
        mem_wr    = 1'b1;
        mem_addr  = c_addr;
        mem_wdata = acc_q;
      end
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench: an N=2 and an N=3 sequencer, each with its own memory and registered ALU model.
module tb_matmul_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n2, start2, busy2, done2, rd2, wr2;
  logic [7:0]  addr2;
  logic [15:0] rdata2, wdata2, in1_2, in2_2, aluo2;
  logic [1:0]  ctl2;

  logic        rst_n3, start3, busy3, done3, rd3, wr3;
  logic [7:0]  addr3;
  logic [15:0] rdata3, wdata3, in1_3, in2_3, aluo3;
  logic [1:0]  ctl3;

  logic [15:0] mem2 [0:255];
  logic [15:0] mem3 [0:255];
  logic [7:0]  waddr3 [$];
  int          wr_cnt2 = 0;
  int          clash = 0;
  logic        busy_hist2 [0:511];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  matmul_sequencer #(.N(2)) u2 (
    .clk(clk), .rst_n(rst_n2), .start(start2), .busy(busy2), .done(done2),
    .mem_addr(addr2), .mem_rd(rd2), .mem_rdata(rdata2), .mem_wr(wr2), .mem_wdata(wdata2),
    .alu_in1(in1_2), .alu_in2(in2_2), .alu_control(ctl2), .alu_out(aluo2)
  );

  matmul_sequencer #(.N(3)) u3 (
    .clk(clk), .rst_n(rst_n3), .start(start3), .busy(busy3), .done(done3),
    .mem_addr(addr3), .mem_rd(rd3), .mem_rdata(rdata3), .mem_wr(wr3), .mem_wdata(wdata3),
    .alu_in1(in1_3), .alu_in2(in2_3), .alu_control(ctl3), .alu_out(aluo3)
  );

  always @(posedge clk) begin
    if (rd2) rdata2 <= mem2[addr2];
    if (wr2) begin
      mem2[addr2] <= wdata2;
      wr_cnt2++;
    end
    if (rd2 && wr2) clash++;
    case (ctl2)
      2'b01:   aluo2 <= in1_2 * in2_2;
      2'b10:   aluo2 <= in1_2 + in2_2;
      default: aluo2 <= aluo2;
    endcase
  end

  always @(posedge clk) begin
    if (rd3) rdata3 <= mem3[addr3];
    if (wr3) begin
      mem3[addr3] <= wdata3;
      waddr3.push_back(addr3);
    end
    if (rd3 && wr3) clash++;
    case (ctl3)
      2'b01:   aluo3 <= in1_3 * in2_3;
      2'b10:   aluo3 <= in1_3 + in2_3;
      default: aluo3 <= aluo3;
    endcase
  end

  task automatic load2(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
    mem2[0] = a0; mem2[1] = a1; mem2[2] = a2; mem2[3] = a3;
    mem2[16] = b0; mem2[17] = b1; mem2[18] = b2; mem2[19] = b3;
    for (int n = 32; n < 36; n++) mem2[n] = 16'hDEAD;
    wr_cnt2 = 0;
  endtask

  // Starts a run on u2 (called at #1 after an edge); cyc = cycle count with the start edge as 0.
  task automatic run2(input int pulse_at, output int cyc);
    start2 = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    start2 = (pulse_at == 1);
    busy_hist2[1] = busy2;
    while (!done2 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start2 = (cyc == pulse_at);
      busy_hist2[cyc] = busy2;
    end
    start2 = 1'b0;
  endtask

  task automatic test_reset;
    total_cnt++;
    if ({busy2, done2, rd2, wr2, addr2, wdata2, in1_2, in2_2, ctl2} !== '0)
      $display("FAIL reset_outputs_n2: got busy=%b done=%b rd=%b wr=%b ctl=%b, required all 0",
               busy2, done2, rd2, wr2, ctl2);
    else pass_cnt++;
    total_cnt++;
    if ({busy3, done3, rd3, wr3, addr3, wdata3, in1_3, in2_3, ctl3} !== '0)
      $display("FAIL reset_outputs_n3: got busy=%b done=%b rd=%b wr=%b ctl=%b, required all 0",
               busy3, done3, rd3, wr3, ctl3);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int cyc;
    load2(1, 2, 3, 4, 5, 6, 7, 8);
    run2(-1, cyc);
    total_cnt++;
    if (cyc !== 61) $display("FAIL basic_done_cycle: got %0d required 61", cyc);
    else pass_cnt++;
    total_cnt++;
    if (busy_hist2[1] !== 1'b1 || busy_hist2[60] !== 1'b1)
      $display("FAIL basic_busy: got %b/%b at cycles 1/60 required 1/1",
               busy_hist2[1], busy_hist2[60]);
    else pass_cnt++;
    total_cnt++;
    if ({mem2[32], mem2[33], mem2[34], mem2[35]} !== {16'd19, 16'd22, 16'd43, 16'd50})
      $display("FAIL basic_result: got %0d %0d %0d %0d required 19 22 43 50",
               mem2[32], mem2[33], mem2[34], mem2[35]);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt2 !== 4) $display("FAIL basic_write_count: got %0d required 4", wr_cnt2);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if ({busy2, done2, ctl2} !== 4'b0)
      $display("FAIL basic_after_done: got busy=%b done=%b ctl=%b required 0 0 00",
               busy2, done2, ctl2);
    else pass_cnt++;
  endtask

  task automatic test_identity_n3;
    int cyc;
    for (int n = 0; n < 9; n++) begin
      mem3[n] = (n % 4 == 0) ? 16'd1 : 16'd0;
      mem3[16 + n] = 16'(n + 1);
      mem3[32 + n] = 16'hDEAD;
    end
    waddr3.delete();
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    cyc = 1;
    while (!done3 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    total_cnt++;
    if (cyc !== 199) $display("FAIL n3_done_cycle: got %0d required 199", cyc);
    else pass_cnt++;
    for (int n = 0; n < 9; n++) begin
      total_cnt++;
      if (mem3[32 + n] !== 16'(n + 1))
        $display("FAIL n3_result[%0d]: got %0d required %0d", n, mem3[32 + n], n + 1);
      else pass_cnt++;
    end
    total_cnt++;
    if (waddr3.size() !== 9) $display("FAIL n3_write_count: got %0d required 9", waddr3.size());
    else begin
      pass_cnt++;
      for (int n = 0; n < 9; n++) begin
        total_cnt++;
        if (waddr3[n] !== 8'(32 + n))
          $display("FAIL n3_write_order[%0d]: got %0d required %0d", n, waddr3[n], 32 + n);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_wrap;
    int cyc;
    load2(256, 256, 256, 256, 256, 256, 256, 256);
    run2(-1, cyc);
    @(posedge clk); #1;
    total_cnt++;
    if ({mem2[32], mem2[33], mem2[34], mem2[35]} !== 64'h0)
      $display("FAIL wrap_256: got %h %h %h %h required 0 0 0 0",
               mem2[32], mem2[33], mem2[34], mem2[35]);
    else pass_cnt++;
    load2(255, 255, 255, 255, 255, 255, 255, 255);
    run2(-1, cyc);
    @(posedge clk); #1;
    total_cnt++;
    if ({mem2[32], mem2[33], mem2[34], mem2[35]} !== {4{16'hFC02}})
      $display("FAIL wrap_255: got %h %h %h %h required fc02 x4",
               mem2[32], mem2[33], mem2[34], mem2[35]);
    else pass_cnt++;
  endtask

  task automatic test_start_while_busy;
    int cyc;
    load2(1, 2, 3, 4, 5, 6, 7, 8);
    run2(20, cyc);
    total_cnt++;
    if (cyc !== 61) $display("FAIL ignore_start_done_cycle: got %0d required 61", cyc);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (wr_cnt2 !== 4 || busy2 !== 1'b0)
      $display("FAIL ignore_start_writes: got %0d writes busy=%b required 4 writes busy=0",
               wr_cnt2, busy2);
    else pass_cnt++;
    total_cnt++;
    if ({mem2[32], mem2[33], mem2[34], mem2[35]} !== {16'd19, 16'd22, 16'd43, 16'd50})
      $display("FAIL ignore_start_result: got %0d %0d %0d %0d required 19 22 43 50",
               mem2[32], mem2[33], mem2[34], mem2[35]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    load2(1, 2, 3, 4, 5, 6, 7, 8);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n2 = 1'b0;
    #1;
    total_cnt++;
    if ({busy2, ctl2, wr2} !== 4'b0)
      $display("FAIL midreset_outputs: got busy=%b ctl=%b wr=%b required 0 00 0", busy2, ctl2, wr2);
    else pass_cnt++;
    repeat (5) @(posedge clk);
    #1;
    total_cnt++;
    if (wr_cnt2 !== 2 || {mem2[32], mem2[33], mem2[34], mem2[35]}
                         !== {16'd19, 16'd22, 16'hDEAD, 16'hDEAD})
      $display("FAIL midreset_partial: got %0d writes C=%h %h %h %h required 2, 0013 0016 dead dead",
               wr_cnt2, mem2[32], mem2[33], mem2[34], mem2[35]);
    else pass_cnt++;
    @(negedge clk);
    rst_n2 = 1'b1;
    @(posedge clk); #1;
    load2(1, 2, 3, 4, 5, 6, 7, 8);
    run2(-1, cyc);
    total_cnt++;
    if (cyc !== 61 || {mem2[32], mem2[33], mem2[34], mem2[35]}
                      !== {16'd19, 16'd22, 16'd43, 16'd50})
      $display("FAIL midreset_rerun: got cycle %0d C=%0d %0d %0d %0d required 61, 19 22 43 50",
               cyc, mem2[32], mem2[33], mem2[34], mem2[35]);
    else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int nd;
    int dc [0:3];
    nd = 0;
    for (int n = 0; n < 4; n++) dc[n] = 0;
    load2(1, 2, 3, 4, 5, 6, 7, 8);
    start2 = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (cyc < 130) begin
      if (done2 && nd < 4) begin
        dc[nd] = cyc;
        nd++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start2 = 1'b0;
    while (busy2 && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    total_cnt++;
    if (nd !== 2) $display("FAIL b2b_done_count: got %0d required 2", nd);
    else pass_cnt++;
    total_cnt++;
    if (dc[0] !== 61 || dc[1] !== 123)
      $display("FAIL b2b_done_cycles: got %0d,%0d required 61,123", dc[0], dc[1]);
    else pass_cnt++;
    total_cnt++;
    if (busy2 !== 1'b0) $display("FAIL b2b_idle: got busy=%b required 0", busy2);
    else pass_cnt++;
    total_cnt++;
    if (clash !== 0) $display("FAIL rd_wr_overlap: got %0d overlaps required 0", clash);
    else pass_cnt++;
  endtask

  initial begin
    rst_n2 = 1'b0;
    rst_n3 = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    aluo2  = '0;
    aluo3  = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n2 = 1'b1;
    rst_n3 = 1'b1;
    @(posedge clk); #1;
    test_basic;
    test_identity_n3;
    test_wrap;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
